// File: rtl/speed_sched_pkg.sv
// -----------------------------------------------------------------------------
// speed_sched_pkg
//   Shared types and defaults for the speed scheduler.
//   - state_t       : scheduler FSM states (IDLE, RUN, PAUSED)
//   - NUM_SPEEDS_DEF: default number of speed pulse inputs
// -----------------------------------------------------------------------------
package speed_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam int NUM_SPEEDS_DEF = 6;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. Grants the first asserted request at or
//   after the pointer, searching cyclically through the request vector.
//   Ports:
//     req_i  in   NUM_REQ  request vector
//     ptr_i  in   PTR_W    index where the search starts
//     gnt_o  out  NUM_REQ  one-hot grant (all zero when nothing requests)
//     any_o  out  1        high when some request was granted
// -----------------------------------------------------------------------------
module rr_arbiter
    import speed_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               any_o
);

    logic [PTR_W-1:0] idx;
    int               pos;

    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            idx = PTR_W'(pos);
            if (!any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/speed_scheduler.sv
// -----------------------------------------------------------------------------
// speed_scheduler
//   Turns the timer cluster's speed pulses into a single game tick. The run
//   starts at the slowest level and steps up one level every TICKS_PER_LEVEL
//   ticks (saturating at the fastest). Each tick is handed to one of NUM_REQ
//   requesters with a round-robin grant.
//
//   Optional feature, macro SPEED_SCHED_OVERRIDE_EN: adds a level override
//   (lvl_override_en / lvl_override). While enabled the level follows the
//   clamped override value, auto-stepping is frozen and tick_cnt holds.
//
//   Ports:
//     clk              in   1           system clock
//     rst              in   1           synchronous reset, active low
//     speed_pulse      in   NUM_SPEEDS  1-cycle pulses, index 0 = slowest
//     start            in   1           pulse: begin a run (IDLE only)
//     pause            in   1           level: hold the scheduler
//     stop             in   1           pulse: abort the run
//     req              in   NUM_REQ     tick requests (level)
//     tick             out  1           registered 1-cycle game tick
//     grant            out  NUM_REQ     one-hot grant, only with tick
//     level            out  LEVEL_W     current speed level
//     running          out  1           high in RUN
//     lvl_override_en  in   1           (macro only) override enable
//     lvl_override     in   LEVEL_W     (macro only) override level
// -----------------------------------------------------------------------------
module speed_scheduler
    import speed_sched_pkg::*;
#(
    parameter  int NUM_SPEEDS      = NUM_SPEEDS_DEF,
    parameter  int TICKS_PER_LEVEL = 16,
    parameter  int NUM_REQ         = 4,
    localparam int LEVEL_W         = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1,
    localparam int CNT_W           = $clog2(TICKS_PER_LEVEL + 1),
    localparam int PTR_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SPEEDS-1:0] speed_pulse,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  stop,
    input  logic [NUM_REQ-1:0]    req,
`ifdef SPEED_SCHED_OVERRIDE_EN
    input  logic                  lvl_override_en,
    input  logic [LEVEL_W-1:0]    lvl_override,
`endif
    output logic                  tick,
    output logic [NUM_REQ-1:0]    grant,
    output logic [LEVEL_W-1:0]    level,
    output logic                  running
);

    localparam logic [1:0]         ST_IDLE   = IDLE;
    localparam logic [1:0]         ST_RUN    = RUN;
    localparam logic [1:0]         ST_PAUSED = PAUSED;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(NUM_SPEEDS - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICKS_PER_LEVEL - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(NUM_REQ - 1);

    logic [1:0]         state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic               tick_q,  tick_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_any;
    logic [PTR_W-1:0]   gnt_idx;
    logic               tick_ev;
    logic               step_en;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .any_o (arb_any)
    );

    // One-hot grant back to an index for the pointer update.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    // A pulse coinciding with pause or stop is dropped rather than deferred.
    assign tick_ev = (state_q == ST_RUN) && !stop && !pause && speed_pulse[level_q];

`ifdef SPEED_SCHED_OVERRIDE_EN
    assign step_en = tick_ev && !lvl_override_en;
`else
    assign step_en = tick_ev;
`endif

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        tick_d  = tick_ev;
        grant_d = tick_ev ? arb_gnt : '0;

        if (tick_ev && arb_any) begin
            ptr_d = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
        end

        // The pulse that wraps tick_cnt still belongs to the old level; the new
        // level selects its pulse from the following cycle.
        if (step_en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (level_q != LEVEL_MAX) begin
                    level_d = level_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!stop && !pause && start) begin
                    state_d = ST_RUN;
                    level_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    level_d = '0;
                    cnt_d   = '0;
                    ptr_d   = '0;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    level_d = '0;
                    cnt_d   = '0;
                    ptr_d   = '0;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef SPEED_SCHED_OVERRIDE_EN
        if (lvl_override_en) begin
            level_d = (lvl_override > LEVEL_MAX) ? LEVEL_MAX : lvl_override;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            tick_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            tick_q  <= tick_d;
            grant_q <= grant_d;
        end
    end

    assign tick    = tick_q;
    assign grant   = grant_q;
    assign level   = level_q;
    assign running = (state_q == ST_RUN);

endmodule
